// File: rtl/cms_ctrl_sequencer.sv
// cms_ctrl_sequencer: replays a loaded (addr, data) table onto the CMS control
// bus as isolated write strobes, holding the monitor disabled while it runs.
// Optional build macro CMS_CTRL_SEQ_WRCOUNT_EN adds a saturating strobe counter
// output wr_count.
module cms_ctrl_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   host_wr_idx,
  input  logic [ADDR_WIDTH-1:0]      host_wr_addr,
  input  logic [DATA_WIDTH-1:0]      host_wr_data,
  input  logic [$clog2(DEPTH):0]     host_count,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       host_err,
  output logic [ADDR_WIDTH-1:0]      ctrl_addr,
  output logic [DATA_WIDTH-1:0]      ctrl_wdata,
  output logic                       ctrl_write_enable,
  output logic                       cms_en
`ifdef CMS_CTRL_SEQ_WRCOUNT_EN
  , output logic [15:0]              wr_count
`endif
);
  localparam int IW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW:0]   DEPTH_V = (IW+1)'(DEPTH);
  localparam logic [GW-1:0] GAP_END = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_GAP, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [IW:0]           idx_q, idx_d, cnt_q, cnt_d, cnt_sat;
  logic [GW-1:0]         gap_q, gap_d;
  logic [ADDR_WIDTH-1:0] tab_addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] tab_data_q [DEPTH];

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic                  err_q, err_d, en_q, en_d;
`ifdef CMS_CTRL_SEQ_WRCOUNT_EN
  logic [15:0]           wr_cnt_q;
`endif

  assign cnt_sat = (host_count > DEPTH_V) ? DEPTH_V : host_count;

  // State, sequencing counters, table storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        tab_addr_q[i] <= '0;
        tab_data_q[i] <= '0;
      end
`ifdef CMS_CTRL_SEQ_WRCOUNT_EN
      wr_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      if (host_wr_en && state_q == S_IDLE) begin
        tab_addr_q[host_wr_idx] <= host_wr_addr;
        tab_data_q[host_wr_idx] <= host_wr_data;
      end
`ifdef CMS_CTRL_SEQ_WRCOUNT_EN
      if (state_d == S_STROBE && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
`endif
    end
  end

  // Next-state: walk SETUP -> STROBE -> GAP per entry; abort wins over everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: if (start) begin
        cnt_d   = cnt_sat;
        idx_d   = '0;
        state_d = (cnt_sat == '0) ? S_DONE : S_SETUP;
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: begin
        state_d = S_GAP;
        gap_d   = '0;
      end
      S_GAP: if (gap_q == GAP_END) begin
        gap_d   = '0;
        idx_d   = idx_q + 1'b1;
        state_d = ((idx_q + 1'b1) == cnt_q) ? S_DONE : S_SETUP;
      end else begin
        gap_d = gap_q + 1'b1;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Outputs are decoded from the next state so they land in the same cycle as it.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = (state_d == S_STROBE);
    busy_d  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
    en_d    = !busy_d;
    err_d   = (state_q != S_IDLE) && (host_wr_en || start);
    if (state_d == S_SETUP) begin
      addr_d  = tab_addr_q[idx_d[IW-1:0]];
      wdata_d = tab_data_q[idx_d[IW-1:0]];
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign host_err          = err_q;
  assign ctrl_addr         = addr_q;
  assign ctrl_wdata        = wdata_q;
  assign ctrl_write_enable = we_q;
  assign cms_en            = en_q;
`ifdef CMS_CTRL_SEQ_WRCOUNT_EN
  assign wr_count          = wr_cnt_q;
`endif
endmodule

// File: tb/tb_cms_ctrl_sequencer.sv
// Bench for cms_ctrl_sequencer: two instances (GAP_CYCLES 1 and 3) share the
// stimulus; a scoreboard holds expected strobe/done/error cycles per instance.
module tb_cms_ctrl_sequencer;
  typedef struct {
    int          cyc;
    logic [7:0]  a;
    logic [63:0] d;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic host_wr_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0]  host_wr_idx = '0;
  logic [7:0]  host_wr_addr = '0;
  logic [63:0] host_wr_data = '0;
  logic [4:0]  host_count = '0;

  logic [1:0] we, busy, done, herr, en;
  logic [1:0][7:0]  ad;
  logic [1:0][63:0] wd;
`ifdef CMS_CTRL_SEQ_WRCOUNT_EN
  logic [1:0][15:0] wrc;
`endif

  int gp[2] = '{1, 3};
  int cyc = 0, t0 = 0, nchk = 0, nerr = 0;
  int bfrom[2] = '{0, 0};
  int bto[2]   = '{0, 0};
  exp_t sq[2][$];
  int   dq[2][$];
  int   eq[2][$];
  exp_t mon_e;
  int   mon_c;
  logic [7:0]  tab_a[16];
  logic [63:0] tab_d[16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cms_ctrl_sequencer #(.GAP_CYCLES(1)) u_dut_g1 (
    .clk(clk), .rst(rst), .host_wr_en(host_wr_en), .host_wr_idx(host_wr_idx),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .host_count(host_count),
    .start(start), .abort(abort), .busy(busy[0]), .done(done[0]), .host_err(herr[0]),
    .ctrl_addr(ad[0]), .ctrl_wdata(wd[0]), .ctrl_write_enable(we[0]), .cms_en(en[0])
`ifdef CMS_CTRL_SEQ_WRCOUNT_EN
    , .wr_count(wrc[0])
`endif
  );

  cms_ctrl_sequencer #(.GAP_CYCLES(3)) u_dut_g3 (
    .clk(clk), .rst(rst), .host_wr_en(host_wr_en), .host_wr_idx(host_wr_idx),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .host_count(host_count),
    .start(start), .abort(abort), .busy(busy[1]), .done(done[1]), .host_err(herr[1]),
    .ctrl_addr(ad[1]), .ctrl_wdata(wd[1]), .ctrl_write_enable(we[1]), .cms_en(en[1])
`ifdef CMS_CTRL_SEQ_WRCOUNT_EN
    , .wr_count(wrc[1])
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Outputs sampled on the falling edge, matched against the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (we[k]) begin
        if (sq[k].size() == 0) chk($sformatf("g%0d_spurious_we", gp[k]), 1, 0);
        else begin
          mon_e = sq[k].pop_front();
          chk($sformatf("g%0d_strobe_cyc", gp[k]), 64'(cyc - t0), 64'(mon_e.cyc - t0));
          chk($sformatf("g%0d_strobe_addr", gp[k]), 64'(ad[k]), 64'(mon_e.a));
          chk($sformatf("g%0d_strobe_data", gp[k]), wd[k], mon_e.d);
        end
      end
      if (done[k]) begin
        if (dq[k].size() == 0) chk($sformatf("g%0d_spurious_done", gp[k]), 1, 0);
        else begin
          mon_c = dq[k].pop_front();
          chk($sformatf("g%0d_done_cyc", gp[k]), 64'(cyc - t0), 64'(mon_c - t0));
        end
      end
      if (herr[k]) begin
        if (eq[k].size() == 0) chk($sformatf("g%0d_spurious_err", gp[k]), 1, 0);
        else begin
          mon_c = eq[k].pop_front();
          chk($sformatf("g%0d_err_cyc", gp[k]), 64'(cyc - t0), 64'(mon_c - t0));
        end
      end
      chk($sformatf("g%0d_busy", gp[k]), 64'(busy[k]), 64'(cyc >= bfrom[k] && cyc < bto[k]));
      chk($sformatf("g%0d_cms_en", gp[k]), 64'(en[k]), 64'(!(cyc >= bfrom[k] && cyc < bto[k])));
    end
  end

  task automatic reset_vals_chk();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("g%0d_rst_addr", gp[k]), 64'(ad[k]), 0);
      chk($sformatf("g%0d_rst_data", gp[k]), wd[k], 0);
      chk($sformatf("g%0d_rst_we", gp[k]), 64'(we[k]), 0);
      chk($sformatf("g%0d_rst_done", gp[k]), 64'(done[k]), 0);
      chk($sformatf("g%0d_rst_err", gp[k]), 64'(herr[k]), 0);
    end
  endtask

  task automatic drain_chk();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("g%0d_strobes_left", gp[k]), 64'(sq[k].size()), 0);
      chk($sformatf("g%0d_done_left", gp[k]), 64'(dq[k].size()), 0);
      chk($sformatf("g%0d_err_left", gp[k]), 64'(eq[k].size()), 0);
    end
  endtask

  task automatic tab_wr(input int i, input logic [7:0] a, input logic [63:0] d);
    @(negedge clk);
    host_wr_en = 1'b1; host_wr_idx = 4'(i); host_wr_addr = a; host_wr_data = d;
    tab_a[i] = a; tab_d[i] = d;
    @(negedge clk);
    host_wr_en = 1'b0;
  endtask

  // Starts a replay at cycle 0 = t0; events later than t0+cut are not expected
  // because an abort or reset is applied in cycle cut.
  task automatic replay(input int n, input int cut);
    int m, per, c;
    exp_t e;
    @(negedge clk);
    m = (n > 16) ? 16 : n;
    t0 = cyc;
    host_count = 5'(n);
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      per = 2 + gp[k];
      for (int i = 0; i < m; i++) begin
        c = t0 + 2 + i * per;
        if (c <= t0 + cut) begin
          e.cyc = c; e.a = tab_a[i]; e.d = tab_d[i];
          sq[k].push_back(e);
        end
      end
      c = t0 + 1 + m * per;
      bfrom[k] = t0 + 1;
      if (c <= t0 + cut) begin
        dq[k].push_back(c);
        bto[k] = c;
      end else begin
        bto[k] = t0 + cut + 1;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_to(input int rel);
    while (cyc < t0 + rel) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin tab_a[i] = '0; tab_d[i] = '0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_vals_chk();

    // Basic replay: four entries, then fill the rest for the saturation run.
    tab_wr(0, 8'd0, 64'd1);
    tab_wr(1, 8'd1, 64'd1);
    tab_wr(2, 8'd2, 64'h8000_0008);
    tab_wr(3, 8'd3, 64'h8000_0040);
    replay(4, 1000);
    wait_to(24);
    drain_chk();

    // Empty replay.
    replay(0, 1000);
    wait_to(4);
    drain_chk();

    // Abort in cycle 6, then a fresh replay from entry 0.
    replay(4, 6);
    wait_to(6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_to(25);
    drain_chk();
    replay(4, 1000);
    wait_to(24);
    drain_chk();

    // Table write and start while busy: dropped, error pulses, timing intact.
    replay(4, 1000);
    wait_to(4);
    host_wr_en = 1'b1; host_wr_idx = 4'd0; host_wr_addr = 8'hA5; host_wr_data = 64'hDEAD;
    start = 1'b1;
    for (int k = 0; k < 2; k++) eq[k].push_back(t0 + 5);
    @(negedge clk);
    host_wr_en = 1'b0; start = 1'b0;
    wait_to(24);
    replay(1, 1000);
    wait_to(8);
    drain_chk();

    // Reset in cycle 5, then replay two cleared entries.
    replay(4, 5);
    wait_to(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_vals_chk();
    for (int i = 0; i < 16; i++) begin tab_a[i] = '0; tab_d[i] = '0; end
    replay(2, 1000);
    wait_to(14);
    drain_chk();

    // Saturation: host_count=20 replays all 16 entries.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) tab_wr(i, 8'(8'h10 + i), {32'hC0DE_0000, 32'(i * 7 + 1)});
    replay(20, 1000);
    wait_to(86);
    drain_chk();
`ifdef CMS_CTRL_SEQ_WRCOUNT_EN
    for (int k = 0; k < 2; k++) chk($sformatf("g%0d_wr_count", gp[k]), 64'(wrc[k]), 16);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
